// File: rtl/lookahead_mp_ram_pkg.sv
// -----------------------------------------------------------------------------
// lookahead_ram_pkg
// Shared types and helpers for the lookahead multiport RAM (lookahead_mp_ram)
// and its read-port slice (lookahead_ram_rd_port).
//
// Contents:
//   ram_state_t    : IDLE / CLEAR / READY sequencer states
//   READ_LATENCY   : 1 by default, 2 when LOOKAHEAD_RAM_OUTPUT_REG_EN is defined
//   num_symbols()  : number of byte-enable symbols in a word
//   merge_symbols(): per-symbol select between an old and a new word
//
// Configuration macro: LOOKAHEAD_RAM_OUTPUT_REG_EN (adds an output register
// stage and a second bypass stage to every read port).
// -----------------------------------------------------------------------------
package lookahead_ram_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      CLEAR = 2'd1,
      READY = 2'd2
   } ram_state_t;

   // Widest word the merge helper handles; callers zero-extend into it and
   // truncate the result back to their own width.
   localparam int LA_MAX_DATA_W = 512;

`ifdef LOOKAHEAD_RAM_OUTPUT_REG_EN
   localparam int READ_LATENCY = 2;
`else
   localparam int READ_LATENCY = 1;
`endif

   function automatic int num_symbols(input int data_width, input int symbol_width);
      return data_width / symbol_width;
   endfunction

   // Bit i of the result comes from new_word when the enable of the symbol
   // holding bit i is set, otherwise from old_word.
   function automatic logic [LA_MAX_DATA_W-1:0] merge_symbols(
      input logic [LA_MAX_DATA_W-1:0] old_word,
      input logic [LA_MAX_DATA_W-1:0] new_word,
      input logic [LA_MAX_DATA_W-1:0] be,
      input int                       symbol_width
   );
      logic [LA_MAX_DATA_W-1:0] result;
      result = old_word;
      for (int i = 0; i < LA_MAX_DATA_W; i++) begin
         if (be[i / symbol_width]) begin
            result[i] = new_word[i];
         end
      end
      return result;
   endfunction

endpackage

// File: rtl/lookahead_mp_ram_rd_port.sv
// -----------------------------------------------------------------------------
// lookahead_ram_rd_port
// One read port of lookahead_mp_ram. Registers the raw memory word together
// with the write that happens in the same cycle, then merges the written
// symbols over the stale memory word so the reader sees post-write contents.
// With LOOKAHEAD_RAM_OUTPUT_REG_EN (READ_LATENCY == 2) a second register stage
// also folds in a write committed one cycle after the read.
//
// Ports:
//   clk, reset_n     : clock, asynchronous active-low reset
//   i_ready          : memory accepts traffic (writer waitrequest is low)
//   i_rd_addr        : read address of this port
//   i_rd_inrange     : i_rd_addr < DEPTH
//   i_mem_rdata      : memory word at i_rd_addr (before this cycle's write)
//   i_wr_commit      : a write is committed this cycle
//   i_wr_addr        : write address
//   i_wr_data        : write data
//   i_wr_be          : per-symbol write enable
//   o_rd_data        : read data, READ_LATENCY cycles after the address
// -----------------------------------------------------------------------------
module lookahead_ram_rd_port
   import lookahead_ram_pkg::*;
#(
   parameter int ADDR_WIDTH   = 4,
   parameter int DATA_WIDTH   = 32,
   parameter int SYMBOL_WIDTH = 8,
   parameter int NUM_SYM      = 4
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  i_ready,
   input  logic [ADDR_WIDTH-1:0] i_rd_addr,
   input  logic                  i_rd_inrange,
   input  logic [DATA_WIDTH-1:0] i_mem_rdata,
   input  logic                  i_wr_commit,
   input  logic [ADDR_WIDTH-1:0] i_wr_addr,
   input  logic [DATA_WIDTH-1:0] i_wr_data,
   input  logic [NUM_SYM-1:0]    i_wr_be,
   output logic [DATA_WIDTH-1:0] o_rd_data
);

   logic                  r_vld_p1;
   logic                  r_byp_p1;
   logic [DATA_WIDTH-1:0] r_mem_p1;
   logic [DATA_WIDTH-1:0] r_wd_p1;
   logic [NUM_SYM-1:0]    r_be_p1;
   logic [NUM_SYM-1:0]    w_be_p1;
   logic [DATA_WIDTH-1:0] w_merged_p1;

   // ---- stage p0 -> p1: sample memory word and the concurrent write ----
   // r_vld_p1 also carries the range check: out-of-range reads return zero.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_vld_p1 <= 1'b0;
         r_byp_p1 <= 1'b0;
      end else begin
         r_vld_p1 <= i_ready && i_rd_inrange;
         r_byp_p1 <= i_wr_commit && (i_rd_addr == i_wr_addr);
      end
   end

   always_ff @(posedge clk) begin
      r_mem_p1 <= i_mem_rdata;
      r_wd_p1  <= i_wr_data;
      r_be_p1  <= i_wr_be;
   end

   assign w_be_p1     = r_byp_p1 ? r_be_p1 : '0;
   assign w_merged_p1 = DATA_WIDTH'(merge_symbols(LA_MAX_DATA_W'(r_mem_p1),
                                                  LA_MAX_DATA_W'(r_wd_p1),
                                                  LA_MAX_DATA_W'(w_be_p1),
                                                  SYMBOL_WIDTH));

   if (READ_LATENCY == 2) begin : g_p2
      logic [ADDR_WIDTH-1:0] r_addr_p1;
      logic                  r_vld_p2;
      logic                  r_byp_p2;
      logic [DATA_WIDTH-1:0] r_data_p2;
      logic [DATA_WIDTH-1:0] r_wd_p2;
      logic [NUM_SYM-1:0]    r_be_p2;
      logic [NUM_SYM-1:0]    w_be_p2;

      always_ff @(posedge clk) begin
         r_addr_p1 <= i_rd_addr;
      end

      // ---- stage p1 -> p2: fold in a write committed one cycle later ----
      // The later write is merged last, so it wins over the p1 result.
      always_ff @(posedge clk or negedge reset_n) begin
         if (!reset_n) begin
            r_vld_p2 <= 1'b0;
            r_byp_p2 <= 1'b0;
         end else begin
            r_vld_p2 <= r_vld_p1;
            r_byp_p2 <= r_vld_p1 && i_wr_commit && (r_addr_p1 == i_wr_addr);
         end
      end

      always_ff @(posedge clk) begin
         r_data_p2 <= w_merged_p1;
         r_wd_p2   <= i_wr_data;
         r_be_p2   <= i_wr_be;
      end

      assign w_be_p2   = r_byp_p2 ? r_be_p2 : '0;
      assign o_rd_data = r_vld_p2
                         ? DATA_WIDTH'(merge_symbols(LA_MAX_DATA_W'(r_data_p2),
                                                     LA_MAX_DATA_W'(r_wd_p2),
                                                     LA_MAX_DATA_W'(w_be_p2),
                                                     SYMBOL_WIDTH))
                         : '0;
   end else begin : g_p1
      assign o_rd_data = r_vld_p1 ? w_merged_p1 : '0;
   end

endmodule

// File: rtl/lookahead_mp_ram.sv
// -----------------------------------------------------------------------------
// lookahead_mp_ram
// Generic state store: one write port, NUM_RD_PORTS independent read ports,
// per-symbol byte enables, read-before-write memory with write-to-read bypass
// so every reader sees post-write contents. Optional clear-on-reset sequencer
// zeroes all DEPTH words (one per cycle, highest address first) before writes
// are accepted.
//
// Parameters: DEPTH, DATA_WIDTH, SYMBOL_WIDTH, ADDR_WIDTH, NUM_RD_PORTS,
//             CLEAR_ON_RESET.
// Configuration macro: LOOKAHEAD_RAM_OUTPUT_REG_EN -- read latency 2 with a
//             two-cycle bypass window; latency 1 when undefined.
//
// Ports:
//   clk             : clock
//   reset_n         : asynchronous active-low reset
//   wr_address      : write address
//   wr_writedata    : write data
//   wr_byteenable   : per-symbol write enable
//   wr_write        : write strobe
//   wr_waitrequest  : high while writes are not accepted (registered)
//   rd_address      : packed read addresses, port k at [k*ADDR_WIDTH +: ADDR_WIDTH]
//   rd_readdata     : packed read data, port k at [k*DATA_WIDTH +: DATA_WIDTH]
// -----------------------------------------------------------------------------
module lookahead_mp_ram
   import lookahead_ram_pkg::*;
#(
   parameter int DEPTH          = 16,
   parameter int DATA_WIDTH     = 32,
   parameter int SYMBOL_WIDTH   = 8,
   parameter int ADDR_WIDTH     = 4,
   parameter int NUM_RD_PORTS   = 2,
   parameter int CLEAR_ON_RESET = 1
) (
   input  logic                               clk,
   input  logic                               reset_n,
   input  logic [ADDR_WIDTH-1:0]              wr_address,
   input  logic [DATA_WIDTH-1:0]              wr_writedata,
   input  logic [DATA_WIDTH/SYMBOL_WIDTH-1:0] wr_byteenable,
   input  logic                               wr_write,
   output logic                               wr_waitrequest,
   input  logic [NUM_RD_PORTS*ADDR_WIDTH-1:0] rd_address,
   output logic [NUM_RD_PORTS*DATA_WIDTH-1:0] rd_readdata
);

   localparam int                    NUM_SYM      = num_symbols(DATA_WIDTH, SYMBOL_WIDTH);
   localparam logic [ADDR_WIDTH:0]   LP_DEPTH     = (ADDR_WIDTH+1)'(DEPTH);
   localparam logic [ADDR_WIDTH-1:0] LP_LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

   ram_state_t            r_state;
   ram_state_t            w_state_nxt;
   logic [ADDR_WIDTH-1:0] r_clear_addr;
   logic                  r_waitrequest;
   logic                  w_wr_commit;
   logic [DATA_WIDTH-1:0] r_mem [DEPTH];

   // Sequencer state, clear pointer and the registered waitrequest.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state       <= IDLE;
         r_clear_addr  <= LP_LAST_ADDR;
         r_waitrequest <= 1'b1;
      end else begin
         r_state       <= w_state_nxt;
         r_waitrequest <= (w_state_nxt != READY);
         if (r_state == CLEAR) begin
            r_clear_addr <= r_clear_addr - 1'b1;
         end
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE:    w_state_nxt = (CLEAR_ON_RESET != 0) ? CLEAR : READY;
         CLEAR:   if (r_clear_addr == '0) w_state_nxt = READY;
         READY:   w_state_nxt = READY;
         default: w_state_nxt = IDLE;
      endcase
   end

   // Writes outside the array or while waitrequest is high vanish silently.
   assign w_wr_commit = wr_write && !r_waitrequest && ({1'b0, wr_address} < LP_DEPTH);

   // Memory array: clear sequencer and user writes never overlap because user
   // writes need READY.
   always_ff @(posedge clk) begin
      if (r_state == CLEAR) begin
         r_mem[r_clear_addr] <= '0;
      end else if (w_wr_commit) begin
         r_mem[wr_address] <= DATA_WIDTH'(merge_symbols(LA_MAX_DATA_W'(r_mem[wr_address]),
                                                        LA_MAX_DATA_W'(wr_writedata),
                                                        LA_MAX_DATA_W'(wr_byteenable),
                                                        SYMBOL_WIDTH));
      end
   end

   for (genvar k = 0; k < NUM_RD_PORTS; k++) begin : g_rd
      logic [ADDR_WIDTH-1:0] w_addr;
      logic                  w_inrange;
      logic [DATA_WIDTH-1:0] w_mem_rdata;

      assign w_addr      = rd_address[k*ADDR_WIDTH +: ADDR_WIDTH];
      assign w_inrange   = ({1'b0, w_addr} < LP_DEPTH);
      assign w_mem_rdata = w_inrange ? r_mem[w_addr] : '0;

      lookahead_ram_rd_port #(
         .ADDR_WIDTH   (ADDR_WIDTH),
         .DATA_WIDTH   (DATA_WIDTH),
         .SYMBOL_WIDTH (SYMBOL_WIDTH),
         .NUM_SYM      (NUM_SYM)
      ) u_rd_port (
         .clk          (clk),
         .reset_n      (reset_n),
         .i_ready      (!r_waitrequest),
         .i_rd_addr    (w_addr),
         .i_rd_inrange (w_inrange),
         .i_mem_rdata  (w_mem_rdata),
         .i_wr_commit  (w_wr_commit),
         .i_wr_addr    (wr_address),
         .i_wr_data    (wr_writedata),
         .i_wr_be      (wr_byteenable),
         .o_rd_data    (rd_readdata[k*DATA_WIDTH +: DATA_WIDTH])
      );
   end

   assign wr_waitrequest = r_waitrequest;

endmodule

// File: tb/tb_lookahead_mp_ram.sv
// -----------------------------------------------------------------------------
// tb_lookahead_mp_ram
// Two instances share one stimulus stream: A (DEPTH=16) and B (DEPTH=12, so
// addresses 12..15 are out of range). A reference model keeps each instance's
// memory as plain arrays, counts posedges since reset release to know when
// writes are accepted, and keeps the last READ_LATENCY read requests per port.
// After every posedge a port must show the model memory at the address it
// requested READ_LATENCY-1 edges earlier (zero if that request was out of
// range or made while not ready).
// -----------------------------------------------------------------------------
module tb_lookahead_mp_ram;
   import lookahead_ram_pkg::*;

   localparam int LAT = READ_LATENCY;
   localparam int NP  = 2;

   logic        clk = 1'b0;
   logic        reset_n;
   logic [3:0]  wr_address;
   logic [31:0] wr_writedata;
   logic [3:0]  wr_byteenable;
   logic        wr_write;
   logic [7:0]  rd_address;
   logic        wait_a, wait_b;
   logic [63:0] rdd_a, rdd_b;

   always #5 clk = ~clk;

   lookahead_mp_ram #(
      .DEPTH(16), .DATA_WIDTH(32), .SYMBOL_WIDTH(8), .ADDR_WIDTH(4),
      .NUM_RD_PORTS(NP), .CLEAR_ON_RESET(1)
   ) u_dut_a (
      .clk(clk), .reset_n(reset_n), .wr_address(wr_address),
      .wr_writedata(wr_writedata), .wr_byteenable(wr_byteenable),
      .wr_write(wr_write), .wr_waitrequest(wait_a),
      .rd_address(rd_address), .rd_readdata(rdd_a)
   );

   lookahead_mp_ram #(
      .DEPTH(12), .DATA_WIDTH(32), .SYMBOL_WIDTH(8), .ADDR_WIDTH(4),
      .NUM_RD_PORTS(NP), .CLEAR_ON_RESET(1)
   ) u_dut_b (
      .clk(clk), .reset_n(reset_n), .wr_address(wr_address),
      .wr_writedata(wr_writedata), .wr_byteenable(wr_byteenable),
      .wr_write(wr_write), .wr_waitrequest(wait_b),
      .rd_address(rd_address), .rd_readdata(rdd_b)
   );

   int checks   = 0;
   int failures = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%08h exp=%08h at %0t", tag, got, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   int          m_depth [2] = '{16, 12};
   logic [31:0] m_mem   [2][16];
   int          m_cnt   [2];
   logic        m_hv    [2][NP][LAT];
   logic [3:0]  m_ha    [2][NP][LAT];

   function automatic void m_reset();
      for (int i = 0; i < 2; i++) begin
         m_cnt[i] = 0;
         for (int a = 0; a < 16; a++) m_mem[i][a] = 32'h0;
         for (int p = 0; p < NP; p++)
            for (int j = 0; j < LAT; j++) begin
               m_hv[i][p][j] = 1'b0;
               m_ha[i][p][j] = 4'h0;
            end
      end
   endfunction

   function automatic logic m_ready(input int i);
      return m_cnt[i] >= m_depth[i] + 1;
   endfunction

   // One posedge with the inputs currently applied.
   task automatic m_edge();
      logic       rdy;
      logic [3:0] a;
      if (!reset_n) return;
      for (int i = 0; i < 2; i++) begin
         rdy = m_ready(i);
         for (int p = 0; p < NP; p++) begin
            for (int j = LAT - 1; j > 0; j--) begin
               m_hv[i][p][j] = m_hv[i][p][j-1];
               m_ha[i][p][j] = m_ha[i][p][j-1];
            end
            a = rd_address[p*4 +: 4];
            m_hv[i][p][0] = rdy && (int'(a) < m_depth[i]);
            m_ha[i][p][0] = a;
         end
         if (wr_write && rdy && (int'(wr_address) < m_depth[i])) begin
            for (int s = 0; s < 4; s++)
               if (wr_byteenable[s]) m_mem[i][wr_address][s*8 +: 8] = wr_writedata[s*8 +: 8];
         end
         if (m_cnt[i] < 1000) m_cnt[i]++;
      end
   endtask

   task automatic check_all();
      logic [63:0] rdd;
      logic        gw;
      logic [31:0] exp;
      for (int i = 0; i < 2; i++) begin
         gw  = (i == 0) ? wait_a : wait_b;
         rdd = (i == 0) ? rdd_a : rdd_b;
         chk($sformatf("wait%0d", i), {31'b0, gw}, {31'b0, !m_ready(i)});
         for (int p = 0; p < NP; p++) begin
            exp = m_hv[i][p][LAT-1] ? m_mem[i][m_ha[i][p][LAT-1]] : 32'h0;
            chk($sformatf("rd%0d_p%0d", i, p), rdd[p*32 +: 32], exp);
         end
      end
   endtask

   task automatic cycle();
      @(posedge clk);
      #1;
      m_edge();
      check_all();
   endtask

   // ---------------- stimulus ----------------
   initial begin
      int n;
      reset_n       = 1'b0;
      wr_address    = 4'h0;
      wr_writedata  = 32'h0;
      wr_byteenable = 4'h0;
      wr_write      = 1'b0;
      rd_address    = 8'h0;
      m_reset();
      repeat (3) cycle();
      chk("rst_wait", {31'b0, wait_a}, 32'd1);
      chk("rst_rd", rdd_a[31:0], 32'h0);

      // Release, then abort the clear part-way through.
      reset_n = 1'b1;
      repeat (7) cycle();
      reset_n = 1'b0;
      #1;
      m_reset();
      check_all();
      chk("midclr_wait", {31'b0, wait_a}, 32'd1);
      repeat (2) cycle();

      // Full clear with writes attempted all the way through it.
      wr_write      = 1'b1;
      wr_address    = 4'd9;
      wr_writedata  = 32'hFFFF_FFFF;
      wr_byteenable = 4'hF;
      rd_address    = 8'h99;
      reset_n       = 1'b1;
      n = 0;
      while (wait_a !== 1'b0 && n < 40) begin
         cycle();
         n++;
      end
      chk("clr_len", 32'(n), 32'd17);
      wr_write = 1'b0;
      repeat (LAT) cycle();
      chk("clr_drop", rdd_a[31:0], 32'h0);

      // Every word of A reads zero on both ports after the clear.
      for (int a = 0; a < 16; a++) begin
         rd_address = {4'(a), 4'(a)};
         repeat (LAT) cycle();
         chk($sformatf("zero_p0_%0d", a), rdd_a[31:0], 32'h0);
         chk($sformatf("zero_p1_%0d", a), rdd_a[63:32], 32'h0);
      end

      // Address 13: real word in A, out of range in B.
      wr_write = 1'b1; wr_address = 4'd13; wr_writedata = 32'h1234_5678; wr_byteenable = 4'hF;
      rd_address = 8'hDD;
      cycle();
      wr_write = 1'b0;
      repeat (LAT) cycle();
      chk("oob_b", rdd_b[31:0], 32'h0);
      chk("inr_a", rdd_a[31:0], 32'h1234_5678);

      // Partial write merged over a full one.
      wr_write = 1'b1; wr_address = 4'd5; wr_writedata = 32'hDEAD_BEEF; wr_byteenable = 4'hF;
      rd_address = 8'h00;
      cycle();
      wr_writedata = 32'h1122_3344; wr_byteenable = 4'b0101;
      rd_address = 8'h05;
      cycle();
      wr_write = 1'b0;
      repeat (LAT - 1) cycle();
      chk("merge_p0", rdd_a[31:0], 32'hDE22_BE44);
      rd_address = 8'h55;
      repeat (LAT) cycle();
      chk("merge_p1", rdd_a[63:32], 32'hDE22_BE44);

      // Same-cycle bypass to both ports.
      wr_write = 1'b1; wr_address = 4'd3; wr_writedata = 32'hAAAA_AAAA; wr_byteenable = 4'hF;
      rd_address = 8'h00;
      cycle();
      wr_writedata = 32'h5555_5555;
      rd_address = 8'h33;
      cycle();
      wr_write = 1'b0;
      repeat (LAT - 1) cycle();
      chk("byp_p0", rdd_a[31:0], 32'h5555_5555);
      chk("byp_p1", rdd_a[63:32], 32'h5555_5555);

      // Two back-to-back writes to the address being read.
      wr_write = 1'b1; wr_address = 4'd2; wr_writedata = 32'h0000_00FF; wr_byteenable = 4'hF;
      rd_address = 8'h02;
      cycle();
      wr_writedata = 32'h0000_AB00; wr_byteenable = 4'b0010;
      cycle();
      wr_write = 1'b0;
      chk("la_p0", rdd_a[31:0], 32'h0000_ABFF);

      // Random traffic, reads biased toward the write address.
      for (int c = 0; c < 10000; c++) begin
         wr_write      = ($urandom_range(0, 1) == 1);
         wr_address    = 4'($urandom_range(0, 15));
         wr_writedata  = $urandom();
         wr_byteenable = 4'($urandom_range(0, 15));
         for (int p = 0; p < NP; p++) begin
            if ($urandom_range(0, 2) == 0) rd_address[p*4 +: 4] = wr_address;
            else                           rd_address[p*4 +: 4] = 4'($urandom_range(0, 15));
         end
         cycle();
      end

      // Reset while ready: outputs drop at once, then a full clear reruns.
      reset_n = 1'b0;
      #1;
      m_reset();
      check_all();
      chk("rst_ready_rd0", rdd_a[31:0], 32'h0);
      chk("rst_ready_rd1", rdd_a[63:32], 32'h0);
      wr_write = 1'b0;
      repeat (2) cycle();
      reset_n = 1'b1;
      for (int c = 0; c < 24; c++) begin
         rd_address = {4'($urandom_range(0, 15)), 4'($urandom_range(0, 15))};
         cycle();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
